uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; legal 5..9.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, >= 2.
REQ-003 Parameter DIV_WIDTH, default 16, width of the baud divider.
REQ-004 Port clk  in  1  clock; rising-edge only.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port en  in  1  transmitter enable; gates the start of new frames only.
REQ-007 Port clk_divider  in  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-008 Port parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 Port two_stop  in  1  1 = two stop bits, 0 = one.
REQ-010 Port wr_valid  in  1  push request.
REQ-011 Port wr_data  in  DATA_WIDTH  push data.
REQ-012 Port wr_ready  out  1  FIFO accepts a push this cycle.
REQ-013 Port flush  in  1  discard all queued FIFO entries.
REQ-014 Port sout  out  1  serial line, idle high.
REQ-015 Port busy  out  1  frame in progress.
REQ-016 Port level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 Port empty / full  out  1 each  level == 0 / level == FIFO_DEPTH.

Function
REQ-018 A push SHALL occur when wr_valid && wr_ready; wr_ready = !full && !flush, combinational.
REQ-019 A pushed word SHALL be poppable no earlier than the next cycle; no bypass path.
REQ-020 Push while full SHALL be refused via wr_ready = 0; a pop in the same cycle SHALL NOT make room for that push.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 flush SHALL zero level and pointers at the next edge.
REQ-023 flush SHALL NOT affect the frame currently on sout.
REQ-024 Bit period SHALL be clk_divider+1 cycles; clk_divider = 0 gives 1 cycle per bit.
REQ-025 clk_divider, parity_mode and two_stop SHALL be latched at frame start and held constant for the whole frame.
REQ-026 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-027 IDLE -> START SHALL occur when en && !empty; the FIFO SHALL pop on that cycle; sout SHALL go low on the next cycle.
REQ-028 START SHALL last 1 bit period with sout = 0.
REQ-029 DATA SHALL send DATA_WIDTH bits, LSB first, 1 bit period each.
REQ-030 PARITY SHALL be sent only when parity is enabled; even mode sends XOR of the data bits, odd mode sends its inverse.
REQ-031 STOP SHALL hold sout = 1 for 1 or 2 bit periods.
REQ-032 At the end of STOP, the FSM SHALL go directly to START with a pop if en && !empty, giving no idle gap between frames; otherwise it SHALL go to IDLE.
REQ-033 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-034 en deasserted mid-frame SHALL let the current frame complete; no further frame SHALL start.

Reset
REQ-035 While rst_n = 0: sout = 1, busy = 0, level = 0, empty = 1, full = 0, FSM = IDLE, baud and bit counters = 0.
REQ-036 Reset mid-frame SHALL abort the frame immediately and drive sout high; FIFO contents SHALL be discarded.
REQ-037 After rst_n rises, the first push SHALL be accepted on the first clock edge.

Verification
REQ-038 Scenario: DATA_WIDTH = 8, clk_divider = 3, parity none, one stop, push 0xA5 -> sout sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; 40-cycle frame; busy high for 40 cycles.
REQ-039 Scenario: even parity, push 0x07 -> parity bit 1; odd parity, push 0x07 -> parity bit 0; two_stop = 1 -> stop high for 2 bit periods.
REQ-040 Scenario: en = 0, push FIFO_DEPTH words -> full = 1, wr_ready = 0, extra push refused; then en = 1 -> all words sent back-to-back in order with no idle gap.
REQ-041 Scenario: clk_divider changed from 3 to 7 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
REQ-042 Scenario: 3 words queued, flush asserted during frame 1 -> frame 1 completes intact; level = 0; sout idle afterwards.
REQ-043 Scenario: rst_n pulsed low mid DATA -> sout = 1 and level = 0 the same cycle; busy = 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO.
// Frame settings are captured at each frame start so the line format never changes mid-frame.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DIV_WIDTH-1:0]          clk_divider,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          wr_valid,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ready,
    input  logic                          flush,
    output logic                          sout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          empty,
    output logic                          full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wrPtr_q, rdPtr_q;
    logic [LW-1:0]         level_q;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] headData;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  baudCnt_q, baudCnt_d;
    logic [DIV_WIDTH-1:0]  divider_q, divider_d;
    logic [BW-1:0]         bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  parityBit_q, parityBit_d;
    logic                  parityEn_q, parityEn_d;
    logic                  twoStop_q, twoStop_d;
    logic                  bitDone;
    logic                  startFrame;

    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign wr_ready = !full && !flush;
    assign push     = wr_valid && wr_ready;
    assign pop      = startFrame;
    assign headData = mem_q[rdPtr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    // Storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            divider_q   <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parityBit_q <= 1'b0;
            parityEn_q  <= 1'b0;
            twoStop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            divider_q   <= divider_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parityBit_q <= parityBit_d;
            parityEn_q  <= parityEn_d;
            twoStop_q   <= twoStop_d;
        end
    end

    assign bitDone = (baudCnt_q == divider_q);

    always_comb begin
        state_d     = state_q;
        baudCnt_d   = '0;
        divider_d   = divider_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parityBit_d = parityBit_q;
        parityEn_d  = parityEn_q;
        twoStop_d   = twoStop_q;
        startFrame  = 1'b0;

        if (state_q != IDLE && !bitDone) baudCnt_d = baudCnt_q + DIV_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (en && !empty) startFrame = 1'b1;
            end
            START: begin
                if (bitDone) state_d = DATA;
            end
            DATA: begin
                if (bitDone) begin
                    shift_d = shift_q >> 1;
                    if (bitCnt_q == BW'(DATA_WIDTH - 1)) begin
                        bitCnt_d = '0;
                        state_d  = parityEn_q ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bitDone) state_d = STOP;
            end
            STOP: begin
                // bitCnt counts completed stop bits when two are configured.
                if (bitDone) begin
                    if (twoStop_q && bitCnt_q == '0) begin
                        bitCnt_d = BW'(1);
                    end else if (en && !empty) begin
                        startFrame = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        bitCnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (startFrame) begin
            state_d     = START;
            baudCnt_d   = '0;
            bitCnt_d    = '0;
            shift_d     = headData;
            divider_d   = clk_divider;
            parityEn_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            parityBit_d = (^headData) ^ parity_mode[1];
            twoStop_d   = two_stop;
        end
    end

    always_comb begin
        sout = 1'b1;
        case (state_q)
            START:   sout = 1'b0;
            DATA:    sout = shift_q[0];
            PARITY:  sout = parityBit_q;
            default: sout = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: words pushed are queued as expected frames and
// compared bit-by-bit, every cycle of every bit period, as they appear on sout.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] clk_divider;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        flush;
    logic        sout;
    logic        busy;
    logic [3:0]  level;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbQ[$];

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .clk_divider(clk_divider),
        .parity_mode(parity_mode),
        .two_stop(two_stop),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .flush(flush),
        .sout(sout),
        .busy(busy),
        .level(level),
        .empty(empty),
        .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge; leaves the bench on the next falling edge.
    task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
        wr_valid = 1'b1;
        wr_data  = data;
        #1;
        checkOutput("wrReady", wr_ready, expectAccept);
        if (expectAccept) sbQ.push_back(data);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic checkLevel(input string tag, input int expLevel, input bit expEmpty, input bit expFull);
        checkOutput({tag, "_level"}, level, expLevel);
        checkOutput({tag, "_empty"}, empty, expEmpty);
        checkOutput({tag, "_full"}, full, expFull);
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        logic obsSout;
        logic obsBusy;
        obsSout = 1'b1;
        obsBusy = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (c != 0) @(negedge clk);
            if (sout !== 1'b1) obsSout = sout;
            if (busy !== 1'b0) obsBusy = busy;
        end
        checkOutput({tag, "_soutIdle"}, obsSout, 1'b1);
        checkOutput({tag, "_busyIdle"}, obsBusy, 1'b0);
    endtask

    // action: 0 none, 1 change divider to 7, 2 pulse flush, 3 drop en (all mid-frame).
    task automatic receiveFrame(input int period, input int parMode, input bit twoStopExp,
                                input int budget, input int action);
        logic [7:0] word;
        logic       expBits[$];
        logic       obsBit;
        logic       obsBusy;
        int         waited;
        waited = 0;
        while (sout !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("startBit", sout, 1'b0);
        if (sout !== 1'b0) return;
        checkOutput("scoreboardHasWord", sbQ.size() > 0, 1'b1);
        if (sbQ.size() == 0) return;
        word = sbQ.pop_front();
        expBits.push_back(1'b0);
        for (int i = 0; i < 8; i++) expBits.push_back(word[i]);
        if (parMode == 1 || parMode == 2) expBits.push_back((^word) ^ (parMode == 2));
        expBits.push_back(1'b1);
        if (twoStopExp) expBits.push_back(1'b1);
        for (int b = 0; b < expBits.size(); b++) begin
            obsBit  = expBits[b];
            obsBusy = 1'b1;
            for (int c = 0; c < period; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (action == 2 && b == 2 && c == 1) flush = 1'b0;
                if (sout !== expBits[b]) obsBit = sout;
                if (busy !== 1'b1) obsBusy = busy;
                if (b == 1 && c == 0 && action == 1) clk_divider = 16'd7;
                if (b == 1 && c == 0 && action == 3) en = 1'b0;
                if (action == 2 && b == 2 && c == 0) begin
                    flush = 1'b1;
                    #1;
                    checkOutput("wrReadyDuringFlush", wr_ready, 1'b0);
                end
            end
            checkOutput($sformatf("frame%02h_bit%0d", word, b), obsBit, expBits[b]);
            checkOutput($sformatf("frame%02h_busy%0d", word, b), obsBusy, 1'b1);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        clk_divider = 16'd3;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = 8'h00;
        flush       = 1'b0;
        #1;
        checkOutput("rstSout", sout, 1'b1);
        checkOutput("rstBusy", busy, 1'b0);
        checkLevel("rst", 0, 1'b1, 1'b0);

        // Basic 8N1 frame, 4-cycle bits, first push right after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'hA5, 1'b1);
        checkLevel("afterPush", 1, 1'b0, 1'b0);
        checkOutput("noBypassSout", sout, 1'b1);
        receiveFrame(4, 0, 1'b0, 4, 0);
        checkIdle("afterA5", 1);

        // Divider change mid-frame applies only to the following frame.
        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        checkOutput("levelPushPop", level, 1);
        receiveFrame(4, 0, 1'b0, 2, 1);
        receiveFrame(8, 0, 1'b0, 0, 0);
        checkIdle("afterDivChange", 3);

        // Even parity, en dropped mid-frame, then odd parity with two stop bits.
        clk_divider = 16'd1;
        en          = 1'b0;
        parity_mode = 2'b01;
        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h07, 1'b1);
        en = 1'b1;
        receiveFrame(2, 1, 1'b0, 3, 3);
        checkLevel("afterEnDrop", 1, 1'b0, 1'b0);
        checkIdle("enLow", 6);
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        en          = 1'b1;
        receiveFrame(2, 2, 1'b1, 3, 0);
        checkIdle("afterOdd", 2);
        two_stop = 1'b0;

        // Fill while disabled, refuse extra push even on the pop cycle, drain back-to-back.
        parity_mode = 2'b11;
        en          = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(8'(i * 37 + 11), 1'b1);
        checkLevel("full", 8, 1'b0, 1'b1);
        checkOutput("wrReadyFull", wr_ready, 1'b0);
        en = 1'b1;
        applyStimulus(8'hEE, 1'b0);
        for (int i = 0; i < 8; i++) receiveFrame(2, 3, 1'b0, (i == 0) ? 2 : 0, 0);
        checkIdle("afterDrain", 4);
        checkLevel("drained", 0, 1'b1, 1'b0);
        parity_mode = 2'b00;

        // Flush during the first of three queued frames.
        en = 1'b0;
        applyStimulus(8'h81, 1'b1);
        applyStimulus(8'h42, 1'b1);
        applyStimulus(8'h24, 1'b1);
        checkLevel("queued3", 3, 1'b0, 1'b0);
        en = 1'b1;
        receiveFrame(2, 0, 1'b0, 3, 2);
        sbQ.delete();
        checkLevel("afterFlush", 0, 1'b1, 1'b0);
        checkIdle("afterFlush", 20);

        // Asynchronous reset in the middle of the data bits.
        clk_divider = 16'd3;
        en          = 1'b0;
        applyStimulus(8'h96, 1'b1);
        applyStimulus(8'h69, 1'b1);
        en = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("busyMidData", busy, 1'b1);
        checkOutput("levelMidData", level, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstSout", sout, 1'b1);
        checkOutput("midRstBusy", busy, 1'b0);
        checkLevel("midRst", 0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sbQ.delete();
        checkIdle("afterRst", 12);
        checkLevel("afterRst", 0, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        receiveFrame(4, 0, 1'b0, 4, 0);
        checkIdle("final", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
